fetch_queue: RTL and testbench

//  Byte-wide instruction prefetch queue feeding the decode stage. Fetches code bytes one at a time

---
 rtl/fetch_queue.sv | 100 ++++++++++
 tb/tb_fetch_queue.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: byte-wide instruction prefetch queue presenting the next 4 code bytes to decode
module fetch_queue #(
    parameter int          DEPTH      = 8,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic                     clk2,
    input  logic                     reset,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    input  logic                     mem_valid,
    input  logic [7:0]               mem_rdata,
    output logic [31:0]              ope,
    output logic                     ope_valid,
    output logic [31:0]              eip,
    input  logic                     consume,
    input  logic [3:0]               consume_len,
    output logic                     consume_ack,
    input  logic                     redirect,
    input  logic [31:0]              redirect_addr,
    output logic [$clog2(DEPTH):0]   fill_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t          state, state_n;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count, count_n, len;
    logic [31:0]     fetch_pc, drop_addr;
    logic [7:0]      buffer [DEPTH];
    logic            push;

    assign len         = CW'(consume_len);
    assign push        = (state == WAIT) && mem_valid && !redirect;
    assign consume_ack = consume && !redirect && len != '0 && len <= count;
    assign count_n     = count + CW'(push) - (consume_ack ? len : '0);
    assign mem_req     = state != IDLE;
    assign mem_addr    = state == DROP ? drop_addr : fetch_pc;
    assign ope_valid   = count >= CW'(4);
    assign fill_level  = count;

    // next fetch state; a redirect while a byte is outstanding parks in DROP to swallow it
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (!redirect && count < FULL) state_n = WAIT;
            WAIT:    if (redirect) state_n = mem_valid ? IDLE : DROP;
                     else if (mem_valid) state_n = count_n < FULL ? WAIT : IDLE;
            DROP:    if (mem_valid) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // queue bookkeeping, addresses and fetch state; redirect overrides consume and push
    always_ff @(posedge clk2) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            eip       <= RESET_ADDR;
            fetch_pc  <= RESET_ADDR;
            drop_addr <= RESET_ADDR;
        end else begin
            state <= state_n;
            if (state == WAIT && redirect && !mem_valid) drop_addr <= fetch_pc;
            if (redirect) begin
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                eip      <= redirect_addr;
                fetch_pc <= redirect_addr;
            end else begin
                count <= count_n;
                if (push) begin
                    wr_ptr   <= wr_ptr + AW'(1);
                    fetch_pc <= fetch_pc + 32'd1;
                end
                if (consume_ack) begin
                    rd_ptr <= rd_ptr + AW'(consume_len);
                    eip    <= eip + 32'(consume_len);
                end
            end
        end
    end

    // byte storage; contents outside the valid window are never shown
    always_ff @(posedge clk2) begin
        if (push && !reset) buffer[wr_ptr] <= mem_rdata;
    end

    // head window: lanes beyond the fill level read as zero
    always_comb begin
        ope = '0;
        for (int i = 0; i < 4; i++)
            if (CW'(i) < count) ope[31 - 8*i -: 8] = buffer[rd_ptr + AW'(i)];
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized bench for fetch_queue against a byte-queue reference model
module tb_fetch_queue;
    localparam int DEPTH = 8;

    logic        clk2, reset, mem_req, mem_valid, ope_valid, consume, consume_ack, redirect;
    logic [31:0] mem_addr, ope, eip, redirect_addr;
    logic [7:0]  mem_rdata;
    logic [3:0]  consume_len, fill_level, last_fill;
    logic        last_ack;

    fetch_queue #(.DEPTH(DEPTH), .RESET_ADDR(32'h0)) dut (
        .clk2(clk2), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata), .ope(ope), .ope_valid(ope_valid),
        .eip(eip), .consume(consume), .consume_len(consume_len), .consume_ack(consume_ack),
        .redirect(redirect), .redirect_addr(redirect_addr), .fill_level(fill_level)
    );

    int nchk = 0, npass = 0;
    int wcnt, lat, lat_lo, lat_hi, consumed;
    logic [7:0]  q[$];
    logic [31:0] m_eip, m_pc, m_drop_addr;
    logic        m_req, m_drop, seen;
    logic [7:0]  prog [8];
    int          lens [5];

    initial clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [7:0] code_at(input logic [31:0] a);
        if (a < 32'd8) return prog[a[2:0]];
        return (a[7:0] * 8'd37) ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] exp_ope();
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++)
            if (i < q.size()) r[31 - 8*i -: 8] = q[i];
        return r;
    endfunction

    function automatic int pick_lat();
        return lat_lo + int'($urandom_range(0, lat_hi - lat_lo));
    endfunction

    task automatic tick();
        logic e_ack, got, req0, dn;
        int   sz;
        mem_valid = m_req && wcnt >= lat;
        mem_rdata = m_req ? code_at(m_drop ? m_drop_addr : m_pc) : 8'($urandom);
        #1;
        sz    = q.size();
        e_ack = consume && !redirect && consume_len != 4'd0 && int'(consume_len) <= sz;
        check("consume_ack", 32'(consume_ack), 32'(e_ack));
        last_ack  = consume_ack;
        last_fill = fill_level;
        @(posedge clk2);
        req0 = m_req;
        got  = m_req && mem_valid;
        if (redirect) begin
            dn = m_req && !mem_valid;
            if (dn && !m_drop) m_drop_addr = m_pc;
            m_drop = dn;
            m_req  = dn;
            q.delete();
            m_eip = redirect_addr;
            m_pc  = redirect_addr;
        end else if (m_drop) begin
            if (mem_valid) begin
                m_drop = 1'b0;
                m_req  = 1'b0;
            end
        end else begin
            if (e_ack) begin
                for (int i = 0; i < int'(consume_len); i++) void'(q.pop_front());
                m_eip += 32'(consume_len);
                consumed += int'(consume_len);
            end
            if (got) begin
                q.push_back(code_at(m_pc));
                m_pc += 32'd1;
                m_req = q.size() < DEPTH;
            end else if (!m_req) m_req = sz < DEPTH;
        end
        if (req0 && mem_valid) begin
            wcnt = 0;
            lat  = pick_lat();
        end else if (req0) wcnt++;
        #1;
        check("mem_req", 32'(mem_req), 32'(m_req));
        check("mem_addr", mem_addr, m_drop ? m_drop_addr : m_pc);
        check("fill_level", 32'(fill_level), 32'(q.size()));
        check("eip", eip, m_eip);
        check("ope_valid", 32'(ope_valid), 32'(q.size() >= 4));
        check("ope", ope, exp_ope());
    endtask

    task automatic do_reset();
        reset = 1'b1; redirect = 1'b0; consume = 1'b0; mem_valid = 1'b0; consume_len = 4'd0;
        @(posedge clk2);
        #1;
        reset = 1'b0;
        q.delete();
        m_eip = 32'h0; m_pc = 32'h0; m_drop_addr = 32'h0; m_req = 1'b0; m_drop = 1'b0;
        wcnt = 0; lat = pick_lat();
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_ope", ope, 32'h0);
        check("rst_ope_valid", 32'(ope_valid), 32'h0);
        check("rst_fill", 32'(fill_level), 32'h0);
        check("rst_eip", eip, 32'h0);
        consume = 1'b1; consume_len = 4'd1;
        #1;
        check("rst_ack", 32'(consume_ack), 32'h0);
        consume = 1'b0;
    endtask

    initial begin
        prog = '{8'h55, 8'h89, 8'hE5, 8'hB8, 8'h01, 8'h00, 8'h00, 8'h00};
        lens = '{1, 2, 3, 5, 6};
        redirect_addr = 32'h0; mem_rdata = 8'h00; consumed = 0;
        lat_lo = 0; lat_hi = 0;
        do_reset();

        // zero-latency fill from reset
        for (int n = 0; n < 20 && q.size() < 4; n++) tick();
        check("fill4_ope", ope, 32'h5589E5B8);
        check("fill4_valid", 32'(ope_valid), 32'h1);
        for (int n = 0; n < 20 && q.size() < 8; n++) tick();
        tick();
        check("full_fill", 32'(fill_level), 32'h8);
        check("full_mem_req", 32'(mem_req), 32'h0);

        // consume from full
        consume = 1'b1; consume_len = 4'd1; tick(); consume = 1'b0;
        check("c1_eip", eip, 32'h1);
        check("c1_ope", ope, 32'h89E5B801);
        consume = 1'b1; consume_len = 4'd2; tick(); consume = 1'b0;
        check("c2_eip", eip, 32'h3);
        check("c2_ope", ope, 32'hB8010000);
        consume = 1'b1; consume_len = 4'd5; tick(); consume = 1'b0;
        check("c5_eip", eip, 32'h8);

        // oversized consume held until enough bytes arrive
        lat_lo = 2; lat_hi = 2;
        redirect = 1'b1; redirect_addr = 32'h40; tick(); redirect = 1'b0;
        consume = 1'b1; consume_len = 4'd5; seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            tick();
            seen = last_ack;
        end
        consume = 1'b0;
        check("hold_ack_seen", 32'(seen), 32'h1);
        check("hold_ack_fill", 32'(last_fill), 32'h5);

        // redirect during a slow fetch drops the late byte
        lat_lo = 3; lat_hi = 3;
        redirect = 1'b1; redirect_addr = 32'h20; tick(); redirect = 1'b0;
        for (int n = 0; n < 10 && m_drop; n++) tick();
        tick();
        redirect = 1'b1; redirect_addr = 32'h100; tick(); redirect = 1'b0;
        check("drop_mem_req", 32'(mem_req), 32'h1);
        check("drop_stale_addr", mem_addr, 32'h20);
        check("drop_eip", eip, 32'h100);
        check("drop_fill", 32'(fill_level), 32'h0);
        for (int n = 0; n < 10 && m_drop; n++) tick();
        tick();
        check("refetch_addr", mem_addr, 32'h100);
        check("refetch_req", 32'(mem_req), 32'h1);

        // redirect, consume and returning byte in one cycle
        lat_lo = 0; lat_hi = 0;
        for (int n = 0; n < 20 && !(m_req && !m_drop && q.size() >= 2); n++) tick();
        consume = 1'b1; consume_len = 4'd1; redirect = 1'b1; redirect_addr = 32'h200;
        tick();
        consume = 1'b0; redirect = 1'b0;
        check("rc_ack", 32'(last_ack), 32'h0);
        check("rc_fill", 32'(fill_level), 32'h0);
        check("rc_mem_req", 32'(mem_req), 32'h0);
        check("rc_eip", eip, 32'h200);

        // random run of mixed-length consumes
        lat_lo = 0; lat_hi = 2; consumed = 0;
        for (int n = 0; n < 3000 && consumed < 40; n++) begin
            consume     = $urandom_range(0, 2) != 0;
            consume_len = 4'(lens[$urandom_range(0, 4)]);
            tick();
        end
        consume = 1'b0;
        check("run40_done", 32'(consumed >= 40), 32'h1);

        // random run with redirects, odd lengths and address wrap
        lat_lo = 0; lat_hi = 3;
        for (int n = 0; n < 1500; n++) begin
            consume       = $urandom_range(0, 2) != 0;
            consume_len   = $urandom_range(0, 7) == 0 ? 4'($urandom_range(0, 15)) : 4'(lens[$urandom_range(0, 4)]);
            redirect      = $urandom_range(0, 19) == 0;
            redirect_addr = $urandom_range(0, 2) == 0 ? 32'hFFFF_FFFA + 32'($urandom_range(0, 4)) : $urandom;
            tick();
        end
        consume = 1'b0; redirect = 1'b0;
        do_reset();

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
